acc: RTL and testbench



---
 rtl/acc.sv | 36 +++
 tb/tb_acc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/acc.sv
// 33-bit accumulator/shift register for a 16x16 sequential shift-and-add multiplier.
// Latency: one Clk edge from control to Saidas. No backpressure; the control FSM sequences Load/Ad/Sh.
// Controls: Load > Ad > Sh priority; Reset clears asynchronously.
module acc (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic        Sh,
  input  logic        Ad,
  input  logic [15:0] Multiplicador,
  input  logic [15:0] Multiplicando,
  input  logic [16:0] Soma,
  output logic [32:0] Saidas
);

  logic [32:0] acc_q;

  // The multiplicand only feeds the external adder; it is carried on this port for wiring convenience.
  logic unused_multiplicando;
  assign unused_multiplicando = ^Multiplicando;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
    end else if (Load) begin
      acc_q <= {17'h0, Multiplicador};
    end else if (Ad) begin
      acc_q[32:16] <= Soma;
    end else if (Sh) begin
      acc_q <= {1'b0, acc_q[32:1]};
    end
  end

  assign Saidas = acc_q;

endmodule

// File: tb/tb_acc.sv
// Directed self-checking bench for acc: reset, load, add, shift, priority and full multiplies.
module tb_acc;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic        Sh;
  logic        Ad;
  logic [15:0] Multiplicador;
  logic [15:0] Multiplicando;
  logic [16:0] Soma;
  logic [32:0] Saidas;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  acc dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Load          (Load),
    .Sh            (Sh),
    .Ad            (Ad),
    .Multiplicador (Multiplicador),
    .Multiplicando (Multiplicando),
    .Soma          (Soma),
    .Saidas        (Saidas)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] exp);
    checks++;
    assert (Saidas === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: Saidas=%h expected=%h", tag, Saidas, exp);
    end
  endtask

  task automatic mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] prod);
    Load = 1'b1; Ad = 1'b0; Sh = 1'b0;
    Multiplicador = a; Multiplicando = b;
    step();
    Load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (Saidas[0]) begin
        Soma = {1'b0, Saidas[32:16]} + {1'b0, Multiplicando};
        Ad = 1'b1;
        step();
        Ad = 1'b0;
      end
      Sh = 1'b1;
      step();
      Sh = 1'b0;
    end
    chk(tag, {1'b0, prod});
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b1; Sh = 1'b0; Ad = 1'b0;
    Multiplicador = 16'hFFFF; Multiplicando = 16'h0000; Soma = 17'h0;

    // Reset overrides Load for several edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", 33'h0);
    end

    Reset = 1'b0;
    Multiplicador = 16'h00FE; Multiplicando = 16'hB0B0;
    step();
    chk("load_00fe", {17'h0, 16'h00FE});

    Multiplicador = 16'h0F0F;
    step();
    chk("load_0f0f", {17'h0, 16'h0F0F});

    Load = 1'b0; Ad = 1'b1; Soma = 17'h0C0C0;
    step();
    chk("ad_preload", {17'h0C0C0, 16'h0F0F});

    Ad = 1'b0; Sh = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("sh_x4", {17'h00C0C, 16'h00F0});

    Sh = 1'b0; Multiplicador = 16'h0070; Ad = 1'b1;
    Soma = 17'h10D0D;
    step();
    chk("ad_carry", {17'h10D0D, 16'h00F0});
    Soma = 17'h1F000;
    step();
    chk("ad_1f000", {17'h1F000, 16'h00F0});
    Soma = 17'h00400;
    step();
    chk("ad_00400", {17'h00400, 16'h00F0});

    Ad = 1'b0; Sh = 1'b1;
    step();
    chk("sh_once", {17'h00200, 16'h0078});
    Sh = 1'b0;

    // Asynchronous reset between edges
    #2 Reset = 1'b1;
    #1 chk("async_reset", 33'h0);
    #1 Reset = 1'b0;
    step();
    chk("after_reset_idle", 33'h0);

    Load = 1'b1; Ad = 1'b1; Sh = 1'b1;
    Multiplicador = 16'h1234; Soma = 17'h1FFFF;
    step();
    chk("prio_load", {17'h0, 16'h1234});

    Load = 1'b0; Soma = 17'h1ABCD;
    step();
    chk("prio_ad_over_sh", {17'h1ABCD, 16'h1234});

    Ad = 1'b0; Sh = 1'b0; Multiplicador = 16'hAAAA; Soma = 17'h05555;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold", {17'h1ABCD, 16'h1234});
    end

    // All-ones then 33 shifts drains to zero
    Load = 1'b1; Multiplicador = 16'hFFFF;
    step();
    Load = 1'b0; Ad = 1'b1; Soma = 17'h1FFFF;
    step();
    chk("all_ones", 33'h1_FFFF_FFFF);
    Ad = 1'b0; Sh = 1'b1;
    step();
    chk("sh_msb_fill", 33'h0_FFFF_FFFF);
    for (int i = 0; i < 31; i++) step();
    chk("sh_x32", 33'h1);
    step();
    chk("sh_x33", 33'h0);
    Sh = 1'b0;

    mult("mul_3x5",       16'h0003, 16'h0005, 32'h0000000F);
    mult("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    mult("mul_00ffx0101", 16'h00FF, 16'h0101, 32'h0000FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
